// File: rtl/global_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package global_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } prefetch_state_t;

  localparam int PREFETCH_DEPTH_DEFAULT = 4;
  localparam int PREFETCH_ENTRY_W       = 62;

  // Next sequential word address; wraps from 0xFFFFFFFC to 0x00000000.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return {addr[31:2] + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO holding {addr[31:2], word} entries; flush wins over push.
module prefetch_fifo
  import global_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH_DEFAULT,
  parameter int WIDTH = PREFETCH_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  // A push into a full FIFO is accepted only when a pop frees the head slot.
  always_comb begin
    do_pop_s  = pop && (count_r != (AW+1)'(0));
    do_push_s = push && ((count_r != (AW+1)'(DEPTH)) || do_pop_s);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= din;
  end

  assign head        = mem_r[rd_ptr_r];
  assign valid       = (count_r != (AW+1)'(0));
  assign full        = (count_r == (AW+1)'(DEPTH));
  assign almost_full = (count_r == (AW+1)'(DEPTH - 1));

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetch buffer between core fetch port and memory.
// Optional PREFETCH_PERF_EN adds saturating hit_count / miss_count ports.
module inst_prefetch
  import global_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cyc,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  output logic [31:0] cpu_dat,
  output logic        cpu_ack,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_adr,
  input  logic [31:0] mem_dat,
  input  logic        mem_ack
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  prefetch_state_t state_r, state_next_s;
  logic [31:0] fetch_addr_r, fetch_addr_next_s, mem_adr_r;
  logic [PREFETCH_ENTRY_W-1:0] head_s;
  logic valid_s, full_s, almost_full_s;
  logic req_s, wr_req_s, hit_s, pending_s, miss_s, push_s;
  logic adr_unused_s;

  assign adr_unused_s = ^cpu_adr[1:0];

  // Request classification; a pending core ack blanks the request for a cycle.
  always_comb begin
    req_s     = cpu_cyc && cpu_stb && !cpu_we && !cpu_ack;
    wr_req_s  = cpu_cyc && cpu_stb && cpu_we && !cpu_ack;
    hit_s     = req_s && valid_s && (head_s[61:32] == cpu_adr[31:2]);
    pending_s = req_s && !valid_s && (state_r == FETCH) &&
                (fetch_addr_r[31:2] == cpu_adr[31:2]);
    miss_s    = req_s && !hit_s && !pending_s;
    push_s    = (state_r == FETCH) && mem_ack && !miss_s;
  end

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(PREFETCH_ENTRY_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .pop         (hit_s),
    .flush       (miss_s),
    .din         ({fetch_addr_r[31:2], mem_dat}),
    .head        (head_s),
    .valid       (valid_s),
    .full        (full_s),
    .almost_full (almost_full_s)
  );

  // State, fetch address and the address presented on the memory bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      fetch_addr_r <= 32'h0000_0000;
      mem_adr_r    <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      fetch_addr_r <= fetch_addr_next_s;
      if (state_next_s == FETCH) mem_adr_r <= fetch_addr_next_s;
      else                       mem_adr_r <= mem_adr_r;
    end
  end

  // Next-state logic; DRAIN keeps the old address on the bus until its ack.
  always_comb begin
    state_next_s      = state_r;
    fetch_addr_next_s = fetch_addr_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_next_s      = FETCH;
          fetch_addr_next_s = {cpu_adr[31:2], 2'b00};
        end else if (!full_s || hit_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (miss_s) begin
          fetch_addr_next_s = {cpu_adr[31:2], 2'b00};
          state_next_s      = mem_ack ? FETCH : DRAIN;
        end else if (mem_ack) begin
          fetch_addr_next_s = next_word_addr(fetch_addr_r);
          state_next_s      = (almost_full_s && !hit_s) ? IDLE : FETCH;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        if (miss_s) fetch_addr_next_s = {cpu_adr[31:2], 2'b00};
        else        fetch_addr_next_s = fetch_addr_r;
        state_next_s = mem_ack ? FETCH : DRAIN;
      end
      default: begin
        state_next_s      = IDLE;
        fetch_addr_next_s = fetch_addr_r;
      end
    endcase
  end

  // Memory bus outputs decode straight from the state register.
  always_comb begin
    mem_cyc = (state_r != IDLE);
    mem_stb = (state_r != IDLE);
    mem_we  = 1'b0;
    mem_sel = 4'b1111;
    mem_adr = mem_adr_r;
  end

  // Core response: one-cycle ack for hits and writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack <= 1'b0;
      cpu_dat <= 32'h0000_0000;
    end else begin
      cpu_ack <= hit_s || wr_req_s;
      if (hit_s) cpu_dat <= head_s[31:0];
      else       cpu_dat <= cpu_dat;
    end
  end

`ifdef PREFETCH_PERF_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'h0000_0000;
      miss_count <= 32'h0000_0000;
    end else begin
      if (hit_s && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (miss_s && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
